// File: rtl/spi_add_pkg.sv
// Shared constants and FSM state type for the SPI adder front end.
package spi_add_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int FRAME_BITS    = 2 * WIDTH_DEFAULT + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_EVAL,
    ST_WAIT_CS
  } state_e;

  function automatic int frame_bits_for(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser for one asynchronous SPI input, plus a third flop
// so rising/falling edges are seen on the synchronised copy.
module spi_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Resetting to 0 means a chip select that is already low after reset
  // never produces a falling edge; a fresh edge is needed to start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], din_i};
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_adder_frontend.sv
// SPI mode-0 slave that feeds an external adder and returns its result in the
// next frame. Optional macro SPI_ADD_SELFCHECK_EN adds a sum self-check.
module spi_adder_frontend
  import spi_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic             frame_done,
  output logic             frame_err
`ifdef SPI_ADD_SELFCHECK_EN
  ,
  output logic             selfcheck_err
`endif
);

  localparam int FB    = frame_bits_for(WIDTH);
  localparam int CNT_W = $clog2(FB + 1);

  localparam int SYN_SCLK = 0;
  localparam int SYN_CS   = 1;
  localparam int SYN_MOSI = 2;

  logic [2:0] syn_in;
  logic [2:0] syn_level;
  logic [2:0] syn_rise;
  logic [2:0] syn_fall;

  assign syn_in = {spi_mosi, spi_cs_n, spi_sclk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      spi_in_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  (syn_in[gi]),
        .level_o(syn_level[gi]),
        .rise_o (syn_rise[gi]),
        .fall_o (syn_fall[gi])
      );
    end
  endgenerate

  logic unused_sync;
  assign unused_sync = ^{syn_level[SYN_SCLK], syn_rise[SYN_MOSI], syn_fall[SYN_MOSI]};

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_level, mosi_level;
  assign sclk_rise  = syn_rise[SYN_SCLK];
  assign sclk_fall  = syn_fall[SYN_SCLK];
  assign cs_rise    = syn_rise[SYN_CS];
  assign cs_fall    = syn_fall[SYN_CS];
  assign cs_level   = syn_level[SYN_CS];
  assign mosi_level = syn_level[SYN_MOSI];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FB-1:0]      rx_q, rx_d;
  logic [FB-1:0]      tx_q, tx_d;
  logic [WIDTH:0]     result_q;
  logic [WIDTH-1:0]   add_a_q, add_b_q;
  logic               add_ci_q;
  logic               frame_done_q, frame_err_q;
  logic               load_add, capture, abort;
  logic [WIDTH-1:0]   pad_bits;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    load_add  = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          tx_d      = {result_q, pad_bits};
        end
      end
      ST_SHIFT: begin
        // A complete frame wins over a chip-select release seen in the same cycle.
        if (bit_cnt_q == CNT_W'(FB)) begin
          state_d = ST_LOAD;
        end else if (cs_rise) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (sclk_rise) begin
            rx_d      = {rx_q[FB-2:0], mosi_level};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (sclk_fall) begin
            tx_d = {tx_q[FB-2:0], 1'b0};
          end
        end
      end
      ST_LOAD: begin
        load_add = 1'b1;
        state_d  = ST_EVAL;
      end
      ST_EVAL: begin
        capture = 1'b1;
        state_d = ST_WAIT_CS;
      end
      ST_WAIT_CS: begin
        if (cs_level) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      result_q     <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_ci_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      if (load_add) begin
        add_a_q  <= rx_q[FB-1 -: WIDTH];
        add_b_q  <= rx_q[WIDTH -: WIDTH];
        add_ci_q <= rx_q[0];
      end
      if (capture) begin
        result_q <= {add_co, add_s};
      end
      frame_done_q <= (state_d == ST_EVAL);
      frame_err_q  <= abort;
    end
  end

`ifdef SPI_ADD_SELFCHECK_EN
  logic [WIDTH:0] ref_sum;
  logic           sum_mismatch;
  logic           chk_flag_q;
  logic           selfcheck_q;

  assign ref_sum      = {1'b0, add_a_q} + {1'b0, add_b_q} + {{WIDTH{1'b0}}, add_ci_q};
  assign sum_mismatch = (ref_sum != {add_co, add_s});

  // chk_flag_q travels back with the result of the same frame; selfcheck_q is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_flag_q  <= 1'b0;
      selfcheck_q <= 1'b0;
    end else if (capture) begin
      chk_flag_q <= sum_mismatch;
      if (sum_mismatch) begin
        selfcheck_q <= 1'b1;
      end
    end
  end

  assign pad_bits      = {chk_flag_q, {(WIDTH-1){1'b0}}};
  assign selfcheck_err = selfcheck_q;
`else
  assign pad_bits = '0;
`endif

  // Raw chip select gates the output so it drops to 0 the moment the master deselects.
  assign spi_miso   = (state_q == ST_SHIFT) & ~spi_cs_n & ~rst & tx_q[FB-1];
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_ci     = add_ci_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_adder_frontend.sv
// Self-checking bench for spi_adder_frontend: random and directed SPI frames
// checked against a behavioural result model (honours SPI_ADD_SELFCHECK_EN).
module tb_spi_adder_frontend;

  localparam int W  = 32;
  localparam int FB = 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [W-1:0] add_a, add_b, add_s;
  logic         add_ci, add_co, frame_done, frame_err;
`ifdef SPI_ADD_SELFCHECK_EN
  logic         selfcheck_err;
`endif

  // External adder, with an override that corrupts the sum.
  logic         force_bad;
  logic [W:0]   adder_sum;
  assign adder_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
  assign add_s     = force_bad ? 32'hDEADBEEF : adder_sum[W-1:0];
  assign add_co    = adder_sum[W];

  always #5 clk = ~clk;

  spi_adder_frontend #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co),
    .frame_done(frame_done),
    .frame_err (frame_err)
`ifdef SPI_ADD_SELFCHECK_EN
    ,
    .selfcheck_err(selfcheck_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  int done_pulses = 0;
  int err_pulses  = 0;
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_pulses++;
    if (frame_err === 1'b1) err_pulses++;
  end

  // Reference model: last result seen by the slave, its mismatch flag, operands.
  logic [W:0]   m_result;
  logic         m_flag;
  logic [W-1:0] m_a, m_b;
  logic         m_ci;

  function automatic logic [FB-1:0] exp_word();
    return {m_result, m_flag, {(W-1){1'b0}}};
  endfunction

  task automatic model_reset();
    m_result = '0; m_flag = 1'b0; m_a = '0; m_b = '0; m_ci = 1'b0;
  endtask

  task automatic model_commit(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    longint unsigned sum;
    logic [63:0] sv;
    sum = longint'(a) + longint'(b) + longint'(ci);
    sv  = sum;
    m_a = a; m_b = b; m_ci = ci;
    m_result = force_bad ? {sv[W], 32'hDEADBEEF} : sv[W:0];
`ifdef SPI_ADD_SELFCHECK_EN
    m_flag = (m_result != sv[W:0]);
`else
    m_flag = 1'b0;
`endif
  endtask

  task automatic half_bit();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [FB-1:0] word, input int nbits,
                           output logic [FB-1:0] got, output logic [15:0] extra);
    got = '0;
    extra = '0;
    spi_cs_n = 1'b0;
    half_bit();
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < FB) ? word[FB-1-i] : 1'($urandom_range(0, 1));
      half_bit();
      if (i < FB) got[FB-1-i] = spi_miso;
      else if (i - FB < 16) extra[i-FB] = spi_miso;
      spi_sclk = 1'b1;
      half_bit();
      spi_sclk = 1'b0;
    end
    half_bit();
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    half_bit();
    half_bit();
    $display("frame bits=%0d mosi=%h miso=%h", nbits, word, got);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (add_a !== '0) begin bad++; $display("FAIL reset_add_a got=%h exp=0", add_a); end
    total++; if (add_b !== '0) begin bad++; $display("FAIL reset_add_b got=%h exp=0", add_b); end
    total++; if (add_ci !== 1'b0) begin bad++; $display("FAIL reset_add_ci got=%b exp=0", add_ci); end
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    rst = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [FB-1:0] got, expw;
    logic [15:0]   extra;
    int d0, e0;
    logic [W-1:0] da [3];
    logic [W-1:0] db [3];
    logic         dc [3];
    da[0] = 32'h00000001; db[0] = 32'hFFFFFFFF; dc[0] = 1'b0;
    da[1] = 32'hAAAAAAAA; db[1] = 32'h55555555; dc[1] = 1'b1;
    da[2] = 32'h12345678; db[2] = 32'h0F0F0F0F; dc[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d0 = done_pulses; e0 = err_pulses; expw = exp_word();
      run_frame({da[k], db[k], dc[k]}, FB, got, extra);
      model_commit(da[k], db[k], dc[k]);
      total++; if (got !== expw) begin bad++; $display("FAIL dir_miso k=%0d got=%h exp=%h", k, got, expw); end
      total++; if ({add_a, add_b, add_ci} !== {m_a, m_b, m_ci})
        begin bad++; $display("FAIL dir_add k=%0d got=%h %h %b exp=%h %h %b", k, add_a, add_b, add_ci, m_a, m_b, m_ci); end
      total++; if (done_pulses - d0 !== 1) begin bad++; $display("FAIL dir_done k=%0d got=%0d exp=1", k, done_pulses - d0); end
      total++; if (err_pulses - e0 !== 0) begin bad++; $display("FAIL dir_err k=%0d got=%0d exp=0", k, err_pulses - e0); end
    end
  endtask

  task automatic test_random();
    logic [FB-1:0] got, expw;
    logic [15:0]   extra;
    logic [W-1:0]  a, b;
    logic          ci;
    int d0;
    for (int k = 0; k < 8; k++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
      if (k == 0) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; ci = 1'b1; end
      d0 = done_pulses; expw = exp_word();
      run_frame({a, b, ci}, FB, got, extra);
      model_commit(a, b, ci);
      total++; if (got !== expw) begin bad++; $display("FAIL rnd_miso k=%0d got=%h exp=%h", k, got, expw); end
      total++; if ({add_a, add_b, add_ci} !== {m_a, m_b, m_ci})
        begin bad++; $display("FAIL rnd_add k=%0d got=%h %h %b exp=%h %h %b", k, add_a, add_b, add_ci, m_a, m_b, m_ci); end
      total++; if (done_pulses - d0 !== 1) begin bad++; $display("FAIL rnd_done k=%0d got=%0d exp=1", k, done_pulses - d0); end
    end
  endtask

  task automatic test_abort();
    logic [FB-1:0] got, expw;
    logic [15:0]   extra;
    int d0, e0;
    d0 = done_pulses; e0 = err_pulses; expw = exp_word();
    run_frame({32'hCAFEF00D, 32'h13572468, 1'b1}, 40, got, extra);
    total++; if (err_pulses - e0 !== 1) begin bad++; $display("FAIL abort_err got=%0d exp=1", err_pulses - e0); end
    total++; if (done_pulses - d0 !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", done_pulses - d0); end
    total++; if ({add_a, add_b, add_ci} !== {m_a, m_b, m_ci})
      begin bad++; $display("FAIL abort_add got=%h %h %b exp=%h %h %b", add_a, add_b, add_ci, m_a, m_b, m_ci); end
    total++; if (got[FB-1 -: 40] !== expw[FB-1 -: 40])
      begin bad++; $display("FAIL abort_miso got=%h exp=%h", got[FB-1 -: 40], expw[FB-1 -: 40]); end
  endtask

  task automatic test_back_to_back_overlong();
    logic [FB-1:0] got, expw;
    logic [15:0]   extra;
    logic [W-1:0]  a, b;
    int d0, e0;
    a = $urandom; b = $urandom;
    d0 = done_pulses; e0 = err_pulses; expw = exp_word();
    run_frame({a, b, 1'b0}, 70, got, extra);
    model_commit(a, b, 1'b0);
    total++; if (got !== expw) begin bad++; $display("FAIL long_miso got=%h exp=%h", got, expw); end
    total++; if (extra[4:0] !== 5'b0) begin bad++; $display("FAIL long_tail got=%b exp=00000", extra[4:0]); end
    total++; if (done_pulses - d0 !== 1) begin bad++; $display("FAIL long_done got=%0d exp=1", done_pulses - d0); end
    total++; if (err_pulses - e0 !== 0) begin bad++; $display("FAIL long_err got=%0d exp=0", err_pulses - e0); end
    total++; if ({add_a, add_b, add_ci} !== {m_a, m_b, m_ci})
      begin bad++; $display("FAIL long_add got=%h %h %b exp=%h %h %b", add_a, add_b, add_ci, m_a, m_b, m_ci); end
  endtask

  task automatic test_reset_midframe();
    logic [FB-1:0] got, expw;
    logic [15:0]   extra;
    int d0, e0;
    d0 = done_pulses; e0 = err_pulses;
    spi_cs_n = 1'b0;
    half_bit();
    for (int i = 0; i < 20; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      half_bit(); spi_sclk = 1'b1; half_bit(); spi_sclk = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({add_a, add_b, add_ci, spi_miso, frame_done, frame_err} !== '0)
      begin bad++; $display("FAIL mid_rst_outputs got=%h %h %b %b %b %b exp=0", add_a, add_b, add_ci, spi_miso, frame_done, frame_err); end
    rst = 1'b0;
    model_reset();
    // Chip select stays low across reset: these edges must not start a frame.
    for (int i = 0; i < 50; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      half_bit(); spi_sclk = 1'b1; half_bit(); spi_sclk = 1'b0;
    end
    half_bit();
    spi_cs_n = 1'b1;
    half_bit(); half_bit();
    total++; if (done_pulses - d0 !== 0 || err_pulses - e0 !== 0)
      begin bad++; $display("FAIL mid_rst_pulses got done=%0d err=%0d exp=0 0", done_pulses - d0, err_pulses - e0); end
    expw = exp_word();
    run_frame({32'd5, 32'd7, 1'b1}, FB, got, extra);
    model_commit(32'd5, 32'd7, 1'b1);
    total++; if (got !== expw) begin bad++; $display("FAIL mid_rst_miso0 got=%h exp=%h", got, expw); end
    total++; if ({add_a, add_b, add_ci} !== {32'd5, 32'd7, 1'b1})
      begin bad++; $display("FAIL mid_rst_add got=%h %h %b exp=5 7 1", add_a, add_b, add_ci); end
    expw = exp_word();
    run_frame({32'd0, 32'd0, 1'b0}, FB, got, extra);
    model_commit(32'd0, 32'd0, 1'b0);
    total++; if (got !== expw || got[FB-1 -: W+1] !== 33'h0_0000_000D)
      begin bad++; $display("FAIL mid_rst_sum got=%h exp=%h", got, expw); end
  endtask

  task automatic test_selfcheck();
    logic [FB-1:0] got, expw;
    logic [15:0]   extra;
    logic          exp_bit;
    force_bad = 1'b1;
    run_frame({32'd1, 32'd2, 1'b0}, FB, got, extra);
    model_commit(32'd1, 32'd2, 1'b0);
    force_bad = 1'b0;
`ifdef SPI_ADD_SELFCHECK_EN
    total++; if (selfcheck_err !== 1'b1) begin bad++; $display("FAIL selfcheck_err got=%b exp=1", selfcheck_err); end
    exp_bit = 1'b1;
`else
    exp_bit = 1'b0;
`endif
    expw = exp_word();
    run_frame({32'd3, 32'd4, 1'b1}, FB, got, extra);
    model_commit(32'd3, 32'd4, 1'b1);
    total++; if (got[FB-1-33] !== exp_bit) begin bad++; $display("FAIL chk_bit34 got=%b exp=%b", got[FB-1-33], exp_bit); end
    total++; if (got !== expw) begin bad++; $display("FAIL chk_miso got=%h exp=%h", got, expw); end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    force_bad = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back_overlong();
    test_reset_midframe();
    test_selfcheck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_adder_frontend.md
SPI_ADDER_FRONTEND -- requirements
Module: spi_adder_frontend

Interface
REQ-001 Parameter WIDTH SHALL exist: WIDTH, default 32, adder operand width; frame length FRAME_BITS = 2*WIDTH+1 (65).
REQ-002 The module SHALL use one clock and a synchronous, active-high reset, on the following ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- spi_sclk  in  1  SPI clock, mode 0, asynchronous to clk
- spi_cs_n  in  1  SPI chip select, active low
- spi_mosi  in  1  serial data in, MSB first
- spi_miso  out  1  serial data out, MSB first
- add_a  out  WIDTH  registered operand A to adder
- add_b  out  WIDTH  registered operand B to adder
- add_ci  out  1  registered carry-in to adder
- add_s  in  WIDTH  adder sum, combinational from add_a/add_b/add_ci
- add_co  in  1  adder carry-out
- frame_done  out  1  one-cycle pulse: result captured
- frame_err  out  1  one-cycle pulse: frame aborted

Function
REQ-003 spi_sclk, spi_cs_n and spi_mosi SHALL pass through 2-flop synchronisers; sclk edges are detected on the synchronised signal; clk SHALL be at least 8x sclk.
REQ-004 The state machine SHALL have states IDLE, SHIFT, LOAD, EVAL, WAIT_CS.
REQ-005 IDLE: on synchronised cs_n falling -> SHIFT; bit_cnt = 0; tx shift register loaded with {result_reg[WIDTH:0], WIDTH zero bits}.
REQ-006 SHIFT: each sclk rising edge SHALL shift spi_mosi into the rx register and increment bit_cnt; each sclk falling edge SHALL shift the tx register.
REQ-007 Inbound frame order SHALL be a[WIDTH-1:0], b[WIDTH-1:0], ci; outbound order co, s[WIDTH-1:0], then padding.
REQ-008 When bit_cnt reaches FRAME_BITS (cycle N) -> LOAD; at the end of cycle N+1, add_a, add_b and add_ci SHALL be loaded from rx.
REQ-009 EVAL (cycle N+2): result_reg <= {add_co, add_s}; frame_done SHALL be high for exactly that one cycle; then -> WAIT_CS.
REQ-010 WAIT_CS: further sclk edges SHALL be ignored and spi_miso SHALL be 0; cs_n high -> IDLE.
REQ-011 cs_n rising in SHIFT before FRAME_BITS bits: frame_err SHALL pulse for one cycle, add_* and result_reg unchanged, -> IDLE.
REQ-012 spi_miso SHALL be 0 whenever cs_n is high (no tristate).
REQ-013 Full duplex: the result of frame k SHALL be returned during frame k+1.

Reset
REQ-014 rst SHALL force state IDLE, bit_cnt 0, rx/tx 0, result_reg 0, add_a 0, add_b 0, add_ci 0, spi_miso 0, frame_done 0, frame_err 0.
REQ-015 rst mid-frame SHALL discard the frame without a frame_done or frame_err pulse; a new frame starts only after a fresh cs_n falling edge.

Configuration
REQ-016 Macro SPI_ADD_SELFCHECK_EN, when defined, SHALL add port selfcheck_err (out, 1) and, in EVAL, compare {add_co, add_s} against add_a+add_b+add_ci computed at WIDTH+1 bits.
REQ-017 With the macro, a mismatch SHALL set selfcheck_err (sticky, cleared only by rst), and outbound bit WIDTH+2 (first padding bit) SHALL carry that frame's mismatch flag.
REQ-018 Without the macro, the port and comparator SHALL be absent and all padding bits SHALL be 0.

Structure
REQ-019 Package spi_add_pkg SHALL hold WIDTH default, FRAME_BITS, and the state enum type.
REQ-020 Sub-module spi_in_sync (2-flop synchroniser plus rise/fall edge detect) SHALL be instantiated per SPI input.

Verification
REQ-021 Reset, frame a=0x00000001 b=0xFFFFFFFF ci=0 -> add_a/add_b/add_ci match; one frame_done pulse; next frame miso = co 1, s 0x00000000.
REQ-022 Frame a=0xAAAAAAAA b=0x55555555 ci=1 -> next frame miso = 1 then 32 zeros, then padding zeros.
REQ-023 cs_n raised after 40 bits -> one frame_err pulse, no frame_done, add_a/add_b/add_ci keep previous values.
REQ-024 70 sclk pulses in one frame -> single frame_done; miso 0 after bit 65; bits 66-70 ignored.
REQ-025 rst asserted after 20 bits -> all outputs 0; next full frame a=5 b=7 ci=1 -> result s=0x0000000D, co=0.
REQ-026 SPI_ADD_SELFCHECK_EN defined, add_s forced to 0xDEADBEEF -> selfcheck_err 1 and outbound bit 34 = 1; macro undefined -> bit 34 = 0.
